// File: rtl/adder_result_stage_pkg.sv
// Shared constants for the adder result stage and any ALU consumer of its flags.
package adder_result_stage_pkg;

  // Bit positions inside the 4-bit {V, C, N, Z} flag vector.
  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Skid buffer occupancy states.
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_EMPTY = 2'd0;  // neither entry valid
  localparam logic [1:0] ST_ONE   = 2'd1;  // main valid
  localparam logic [1:0] ST_FULL  = 2'd2;  // main and skid valid

endpackage

// File: rtl/adder_result_stage_if.sv
// Bus bundle between the adder, the result stage and its downstream consumer.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. The producer holds valid and its data stable until that edge; ready
// may change freely and never depends combinationally on valid.
interface adder_result_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [3:0]       out_flags;
  logic [15:0]      out_count;

  // Stage side.
  modport slave (
    input  in_valid, inA, inB, sum, cout, out_ready,
    output in_ready, out_valid, out_sum, out_flags, out_count
  );

  // Environment side: drives the adder result, consumes the stage output.
  modport master (
    output in_valid, inA, inB, sum, cout, out_ready,
    input  in_ready, out_valid, out_sum, out_flags, out_count
  );
endinterface

// File: rtl/adder_result_stage_flag_gen.sv
// Combinational {V, C, N, Z} flag generation from an adder's operands and result.
module alu_flag_gen
  import adder_result_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic [3:0]       flags
);

  // Signed overflow: operands share a sign and the sum's sign differs from it.
  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (sum == '0);
    flags[FLAG_N] = sum[WIDTH-1];
    flags[FLAG_C] = cout;
    flags[FLAG_V] = (inA[WIDTH-1] == inB[WIDTH-1]) && (sum[WIDTH-1] != inA[WIDTH-1]);
  end

endmodule

// File: rtl/adder_result_stage.sv
// Registered adder result stage: two-entry skid buffer carrying sum and flags,
// plus a count of delivered results. in_ready is a flop so out_ready never
// reaches the upstream combinationally.
module adder_result_stage
  import adder_result_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  adder_result_stage_if.slave  bus,
  output logic [1:0]           fsm_state
);

  state_t           state;
  state_t           state_next;
  logic             in_ready_q;
  logic [WIDTH-1:0] main_sum;
  logic [3:0]       main_flags;
  logic [WIDTH-1:0] skid_sum;
  logic [3:0]       skid_flags;
  logic [3:0]       in_flags;
  logic [15:0]      count;
  logic             in_xfer;
  logic             out_xfer;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  // Flags are derived once, from the result being accepted.
  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .inA   (bus.inA),
    .inB   (bus.inB),
    .sum   (bus.sum),
    .cout  (bus.cout),
    .flags (in_flags)
  );

  assign in_xfer  = bus.in_valid && in_ready_q;
  assign out_xfer = (state != ST_EMPTY) && bus.out_ready;

  // Entry load enables decoded from state and the two transfers.
  assign load_main_in   = in_xfer && ((state == ST_EMPTY) || ((state == ST_ONE) && out_xfer));
  assign load_main_skid = (state == ST_FULL) && out_xfer;
  assign load_skid      = (state == ST_ONE) && in_xfer && !out_xfer;

  // Occupancy transitions.
  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (in_xfer) state_next = ST_ONE;
      ST_ONE: begin
        if (in_xfer && !out_xfer)      state_next = ST_FULL;
        else if (!in_xfer && out_xfer) state_next = ST_EMPTY;
      end
      ST_FULL:  if (out_xfer) state_next = ST_ONE;
      default:  state_next = ST_EMPTY;
    endcase
  end

  // Control state: occupancy, registered ready, delivered-result counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      count      <= '0;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != ST_FULL);
      if (out_xfer) count <= count + 16'd1;
    end
  end

  // Datapath entries: main feeds the outputs, skid absorbs one extra result.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_sum   <= '0;
      main_flags <= '0;
      skid_sum   <= '0;
      skid_flags <= '0;
    end else begin
      if (load_main_in) begin
        main_sum   <= bus.sum;
        main_flags <= in_flags;
      end else if (load_main_skid) begin
        main_sum   <= skid_sum;
        main_flags <= skid_flags;
      end
      if (load_skid) begin
        skid_sum   <= bus.sum;
        skid_flags <= in_flags;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state != ST_EMPTY);
  assign bus.out_sum   = main_sum;
  assign bus.out_flags = main_flags;
  assign bus.out_count = count;
  assign fsm_state     = state;

endmodule

// File: tb/tb_adder_result_stage.sv
// Bench for adder_result_stage: directed vectors, scoreboard queue filled at
// input acceptance and drained by a monitor at each output transfer.
module tb_adder_result_stage;

  localparam int WIDTH = 32;

  logic       clk;
  logic       rst;
  logic [1:0] fsm_state;

  adder_result_stage_if #(.WIDTH(WIDTH)) bus ();

  adder_result_stage #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [WIDTH+3:0] exp_q[$];
  logic [WIDTH+3:0] cur_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops on each output transfer, records each input acceptance.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %h with nothing expected",
                   {bus.out_sum, bus.out_flags});
        end else begin
          check("result", 64'({bus.out_sum, bus.out_flags}), 64'(exp_q.pop_front()));
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(cur_exp);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                       input logic c, input logic [3:0] f);
    bus.inA      = a;
    bus.inB      = b;
    bus.sum      = s;
    bus.cout     = c;
    bus.in_valid = 1'b1;
    cur_exp      = {s, f};
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Back-to-back values base+1..base+n with inB=0, so sum=inA, small and
  // nonzero: every flag is 0. Counts cycles where in_ready dropped.
  task automatic stream(input int n, input int base, output int drops);
    drops = 0;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= n; i++) begin
      drive(32'(base + i), 32'h0, 32'(base + i), 1'b0, 4'b0000);
      if (bus.in_ready !== 1'b1) drops++;
      @(posedge clk);
      #1;
    end
    idle_in();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  logic [31:0] va[4] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00000005};
  logic [31:0] vb[4] = '{32'h00000001, 32'h00000001, 32'h80000000, 32'h00000003};
  logic [31:0] vs[4] = '{32'h80000000, 32'h00000000, 32'h00000000, 32'h00000008};
  logic        vc[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [3:0]  vf[4] = '{4'b1010, 4'b0101, 4'b1101, 4'b0000};

  int drops;
  int stale;

  initial begin
    bus.inA = '0; bus.inB = '0; bus.sum = '0; bus.cout = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    cur_exp = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state.
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_sum",   64'(bus.out_sum),   64'd0);
    check("rst_out_flags", 64'(bus.out_flags), 64'd0);
    check("rst_out_count", 64'(bus.out_count), 64'd0);
    check("rst_state",     64'(fsm_state),     64'd0);

    // Single results with out_ready=1: one-cycle latency, flags per vector.
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(va[k], vb[k], vs[k], vc[k], vf[k]);
      @(posedge clk);
      #1;
      idle_in();
      check("latency_out_valid", 64'(bus.out_valid), 64'd1);
      check("vec_out_flags",     64'(bus.out_flags), 64'(vf[k]));
      @(posedge clk);
      #1;
      check("vec_out_count",     64'(bus.out_count), 64'(k + 1));
    end

    // Backpressure: two accepted, third held until downstream drains.
    bus.out_ready = 1'b0;
    drive(32'd1, 32'd0, 32'd1, 1'b0, 4'b0000);
    @(posedge clk);
    #1;
    drive(32'd2, 32'd0, 32'd2, 1'b0, 4'b0000);
    @(posedge clk);
    #1;
    drive(32'd3, 32'd0, 32'd3, 1'b0, 4'b0000);
    check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    check("bp_state_full",   64'(fsm_state),    64'd2);
    check("bp_head",         64'(bus.out_sum),  64'd1);
    repeat (2) @(posedge clk);
    #1;
    check("bp_hold_sum",     64'(bus.out_sum),  64'd1);
    check("bp_hold_ready",   64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    idle_in();
    @(posedge clk);
    #1;
    check("bp_count",        64'(bus.out_count), 64'd7);
    check("bp_drained",      64'(bus.out_valid), 64'd0);

    // Reset while FULL, with transfers requested on both sides.
    bus.out_ready = 1'b0;
    drive(32'h11, 32'd0, 32'h11, 1'b0, 4'b0000);
    @(posedge clk);
    #1;
    drive(32'h22, 32'd0, 32'h22, 1'b0, 4'b0000);
    @(posedge clk);
    #1;
    drive(32'h33, 32'd0, 32'h33, 1'b0, 4'b0000);
    check("pre_rst_full", 64'(fsm_state), 64'd2);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    check("midrst_out_count", 64'(bus.out_count), 64'd0);
    check("midrst_out_sum",   64'(bus.out_sum),   64'd0);
    rst = 1'b0;
    idle_in();
    stale = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) stale++;
    end
    check("midrst_no_stale", 64'(stale), 64'd0);

    // Full throughput: 100 results, one per cycle.
    do_reset();
    stream(100, 0, drops);
    check("tput_ready_drops", 64'(drops),         64'd0);
    check("tput_count",       64'(bus.out_count), 64'd100);

    // Counter wrap.
    do_reset();
    stream(65535, 16, drops);
    check("wrap_pre_count", 64'(bus.out_count), 64'hFFFF);
    stream(1, 7, drops);
    check("wrap_count",     64'(bus.out_count), 64'h0);

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
